// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
// Contents:
//   fetch_state_e  fetch FSM states
//   fetch_entry_t  output buffer entry {instr, pc, err}
//   INSTR_BYTES    PC increment per sequential fetch
//   FIFO_DEPTH     output buffer depth
package fetch_pkg;

  localparam int FETCH_DATA_WIDTH  = 64;
  localparam int FETCH_INSTR_WIDTH = 32;
  localparam int INSTR_BYTES       = 4;
  localparam int FIFO_DEPTH        = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FLUSH
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_INSTR_WIDTH-1:0] instr;
    logic [FETCH_DATA_WIDTH-1:0]  pc;
    logic                         err;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - 2-entry FIFO holding fetched instructions for decode
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_push/i_entry  write one entry
//   i_pop           consume the head entry
//   i_flush         empty the buffer; overrides push and pop
//   o_head/o_valid  head entry and its valid flag
//   o_count         number of stored entries
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_entry,
  output fetch_entry_t o_head,
  output logic         o_valid,
  output logic [1:0]   o_count
);

  localparam logic [1:0] FULL = 2'(FIFO_DEPTH);

  fetch_entry_t mem_q [FIFO_DEPTH];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = i_pop && (count_q != 2'd0);
  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_push = i_push && ((count_q != FULL) || do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (i_flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= i_entry;
        wr_ptr_q        <= !wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= !rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_valid = (count_q != 2'd0);
  assign o_count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch: PC update, imem requests, decode buffer
// Optional feature macro: FETCH_PERF_CNT_EN (adds o_fetch_cnt / o_stall_cnt)
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_pc, o_pc_next, o_pc_en       PC register interface (this block drives its load)
//   i_redirect, i_redirect_pc      branch/jump-taken pulse and target
//   o_imem_req_*, i_imem_req_ready instruction memory request handshake
//   i_imem_rsp_*                   instruction memory response
//   o_instr_*, i_instr_ready       buffered instruction head towards decode
//   o_fetch_cnt, o_stall_cnt       performance counters (FETCH_PERF_CNT_EN only)
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH  = FETCH_DATA_WIDTH,
  parameter int INSTR_WIDTH = FETCH_INSTR_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [DATA_WIDTH-1:0]  i_pc,
  output logic [DATA_WIDTH-1:0]  o_pc_next,
  output logic                   o_pc_en,
  input  logic                   i_redirect,
  input  logic [DATA_WIDTH-1:0]  i_redirect_pc,
  output logic                   o_imem_req_valid,
  output logic [DATA_WIDTH-1:0]  o_imem_req_addr,
  input  logic                   i_imem_req_ready,
  input  logic                   i_imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] i_imem_rsp_data,
  input  logic                   i_imem_rsp_err,
  output logic                   o_instr_valid,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [DATA_WIDTH-1:0]  o_instr_pc,
  output logic                   o_instr_err,
  input  logic                   i_instr_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            o_fetch_cnt,
  output logic [31:0]            o_stall_cnt
`endif
);

  localparam logic [1:0] FULL = 2'(FIFO_DEPTH);

  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] req_pc_q;
  logic [1:0]            count;
  logic [1:0]            count_post;
  logic                  req_fire;
  logic                  push;
  logic                  pop;
  logic                  flush;
  fetch_entry_t          push_entry;
  fetch_entry_t          head;

  // A redirect suppresses the request so that no fetch is issued from the stale PC.
  assign o_imem_req_valid = (state_q == S_REQ) && !i_redirect;
  assign o_imem_req_addr  = (state_q == S_REQ) ? i_pc : '0;
  assign req_fire         = o_imem_req_valid && i_imem_req_ready;
  assign pop              = o_instr_valid && i_instr_ready;
  assign count_post       = pop ? count : count + 2'd1;

  always_comb begin
    state_d   = state_q;
    o_pc_en   = 1'b0;
    o_pc_next = '0;
    push      = 1'b0;
    flush     = 1'b0;
    if (i_redirect) begin
      o_pc_en   = 1'b1;
      o_pc_next = i_redirect_pc;
      flush     = 1'b1;
      // WAIT and FLUSH are exactly the states with a request in flight; a response
      // in this same cycle closes it, so nothing is left to discard.
      if ((state_q == S_WAIT || state_q == S_FLUSH) && !i_imem_rsp_valid)
        state_d = S_FLUSH;
      else
        state_d = S_REQ;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_REQ;
        S_REQ:   if (req_fire) state_d = S_WAIT;
        S_WAIT: begin
          if (i_imem_rsp_valid) begin
            push      = 1'b1;
            o_pc_en   = 1'b1;
            o_pc_next = i_pc + DATA_WIDTH'(INSTR_BYTES);
            state_d   = (count_post < FULL) ? S_REQ : S_HOLD;
          end
        end
        S_HOLD:  if (count < FULL) state_d = S_REQ;
        S_FLUSH: if (i_imem_rsp_valid) state_d = S_REQ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      req_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (req_fire) req_pc_q <= i_pc;
    end
  end

  assign push_entry.instr = i_imem_rsp_data;
  assign push_entry.pc    = req_pc_q;
  assign push_entry.err   = i_imem_rsp_err;

  fetch_buffer u_buffer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_pop   (pop),
    .i_flush (flush),
    .i_entry (push_entry),
    .o_head  (head),
    .o_valid (o_instr_valid),
    .o_count (count)
  );

  assign o_instr     = head.instr;
  assign o_instr_pc  = head.pc;
  assign o_instr_err = head.err;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_fetch_cnt <= '0;
      o_stall_cnt <= '0;
    end else begin
      if (push) o_fetch_cnt <= o_fetch_cnt + 32'd1;
      if (state_q == S_HOLD || (state_q == S_REQ && !i_imem_req_ready))
        o_stall_cnt <= o_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic [63:0] i_pc = '0;
  logic [63:0] o_pc_next;
  logic        o_pc_en;
  logic        i_redirect = 1'b0;
  logic [63:0] i_redirect_pc = '0;
  logic        o_imem_req_valid;
  logic [63:0] o_imem_req_addr;
  logic        i_imem_req_ready = 1'b1;
  logic        i_imem_rsp_valid = 1'b0;
  logic [31:0] i_imem_rsp_data = '0;
  logic        i_imem_rsp_err = 1'b0;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [63:0] o_instr_pc;
  logic        o_instr_err;
  logic        i_instr_ready = 1'b1;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] o_fetch_cnt;
  logic [31:0] o_stall_cnt;
  logic [31:0] fetch_snap;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  int          mem_lat   = 1;
  logic [63:0] err_addr  = 64'hFFFF_FFFF_FFFF_FFFF;
  logic        pend      = 1'b0;
  logic [63:0] pend_addr = '0;
  int          pend_left = 0;

  always #5 i_clk = ~i_clk;

  instr_fetch_unit dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_pc             (i_pc),
    .o_pc_next        (o_pc_next),
    .o_pc_en          (o_pc_en),
    .i_redirect       (i_redirect),
    .i_redirect_pc    (i_redirect_pc),
    .o_imem_req_valid (o_imem_req_valid),
    .o_imem_req_addr  (o_imem_req_addr),
    .i_imem_req_ready (i_imem_req_ready),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .i_imem_rsp_err   (i_imem_rsp_err),
    .o_instr_valid    (o_instr_valid),
    .o_instr          (o_instr),
    .o_instr_pc       (o_instr_pc),
    .o_instr_err      (o_instr_err),
    .i_instr_ready    (i_instr_ready)
`ifdef FETCH_PERF_CNT_EN
    ,
    .o_fetch_cnt      (o_fetch_cnt),
    .o_stall_cnt      (o_stall_cnt)
`endif
  );

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [63:0] ra;
    logic        pe;
    logic [63:0] pn;
    logic        iv;
    logic [31:0] ins;
    logic [63:0] ipc;
  } vec_t;

  vec_t vt [12];

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [63:0] ra,
                              input logic pe, input logic [63:0] pn, input logic iv,
                              input logic [31:0] ins, input logic [63:0] ipc);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.ra = ra; v.pe = pe;
    v.pn = pn; v.iv = iv; v.ins = ins; v.ipc = ipc;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'h13 + (a[31:0] << 12);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Environment for one clock edge: PC register load and a fixed-latency memory.
  task automatic nxt();
    logic        ld, acc;
    logic [63:0] nv, a;
    ld  = o_pc_en;
    nv  = o_pc_next;
    acc = o_imem_req_valid && i_imem_req_ready;
    a   = o_imem_req_addr;
    @(posedge i_clk);
    #1;
    i_redirect       = 1'b0;
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data  = '0;
    i_imem_rsp_err   = 1'b0;
    if (ld) i_pc = nv;
    if (acc) begin
      pend      = 1'b1;
      pend_addr = a;
      pend_left = mem_lat;
    end
    if (pend) begin
      pend_left--;
      if (pend_left == 0) begin
        pend             = 1'b0;
        i_imem_rsp_valid = 1'b1;
        i_imem_rsp_data  = mem_word(pend_addr);
        i_imem_rsp_err   = (pend_addr == err_addr);
      end
    end
    @(negedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst_n          = 1'b0;
    i_redirect       = 1'b0;
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data  = '0;
    i_imem_rsp_err   = 1'b0;
    i_pc             = '0;
    pend             = 1'b0;
    #1;
    chk("rst_pc_en", o_pc_en, 0);
    chk("rst_pc_next", o_pc_next, 0);
    chk("rst_req_valid", o_imem_req_valid, 0);
    chk("rst_req_addr", o_imem_req_addr, 0);
    chk("rst_instr_valid", o_instr_valid, 0);
    chk("rst_instr", o_instr, 0);
    chk("rst_instr_pc", o_instr_pc, 0);
    chk("rst_instr_err", o_instr_err, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_fetch_cnt", o_fetch_cnt, 0);
    chk("rst_stall_cnt", o_stall_cnt, 0);
`endif
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
  endtask

  initial begin
    // Reset release, 1-cycle memory, backpressure to S_HOLD, then release.
    vt[0]  = mk(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 32'h0,    64'h0);
    vt[1]  = mk(1'b1, 1'b1, 64'h0, 1'b0, 64'h0, 1'b0, 32'h0,    64'h0);
    vt[2]  = mk(1'b1, 1'b0, 64'h0, 1'b1, 64'h4, 1'b0, 32'h0,    64'h0);
    vt[3]  = mk(1'b0, 1'b1, 64'h4, 1'b0, 64'h0, 1'b1, 32'h13,   64'h0);
    vt[4]  = mk(1'b0, 1'b0, 64'h0, 1'b1, 64'h8, 1'b1, 32'h13,   64'h0);
    vt[5]  = mk(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 32'h13,   64'h0);
    vt[6]  = mk(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 32'h13,   64'h0);
    vt[7]  = mk(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 32'h13,   64'h0);
    vt[8]  = mk(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 32'h4013, 64'h4);
    vt[9]  = mk(1'b0, 1'b1, 64'h8, 1'b0, 64'h0, 1'b1, 32'h4013, 64'h4);
    vt[10] = mk(1'b1, 1'b0, 64'h0, 1'b1, 64'hC, 1'b1, 32'h4013, 64'h4);
    vt[11] = mk(1'b1, 1'b1, 64'hC, 1'b0, 64'h0, 1'b1, 32'h8013, 64'h8);

    mem_lat = 1;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      i_instr_ready = vt[i].rdy;
      #1;
      chk($sformatf("c%0d_req_valid", i + 1), o_imem_req_valid, vt[i].rv);
      chk($sformatf("c%0d_req_addr", i + 1), o_imem_req_addr, vt[i].ra);
      chk($sformatf("c%0d_pc_en", i + 1), o_pc_en, vt[i].pe);
      chk($sformatf("c%0d_pc_next", i + 1), o_pc_next, vt[i].pn);
      chk($sformatf("c%0d_instr_valid", i + 1), o_instr_valid, vt[i].iv);
      if (vt[i].iv) begin
        chk($sformatf("c%0d_instr", i + 1), o_instr, vt[i].ins);
        chk($sformatf("c%0d_instr_pc", i + 1), o_instr_pc, vt[i].ipc);
      end
`ifdef FETCH_PERF_CNT_EN
      if (i == 11) begin
        chk("perf_fetch_cnt", o_fetch_cnt, 3);
        chk("perf_stall_cnt", o_stall_cnt, 4);
      end
`endif
      nxt();
    end

    // Redirect while a 2-cycle response is in flight: stale data must be dropped.
    do_reset();
    mem_lat       = 2;
    i_instr_ready = 1'b1;
    nxt();
    chk("fl_req_valid", o_imem_req_valid, 1);
    nxt();
    i_redirect    = 1'b1;
    i_redirect_pc = 64'h100;
    #1;
    chk("fl_redir_pc_en", o_pc_en, 1);
    chk("fl_redir_pc_next", o_pc_next, 64'h100);
    chk("fl_redir_req_valid", o_imem_req_valid, 0);
    nxt();
    chk("fl_stale_pc_en", o_pc_en, 0);
    chk("fl_stale_req_valid", o_imem_req_valid, 0);
    nxt();
    chk("fl_req_valid2", o_imem_req_valid, 1);
    chk("fl_req_addr2", o_imem_req_addr, 64'h100);
    chk("fl_fifo_empty", o_instr_valid, 0);
    nxt();
    nxt();
    chk("fl_rsp_pc_next", o_pc_next, 64'h104);
    mem_lat = 1;
    nxt();
    chk("fl_instr_valid", o_instr_valid, 1);
    chk("fl_instr", o_instr, 32'h0010_0013);
    chk("fl_instr_pc", o_instr_pc, 64'h100);
    chk("fl_req_addr3", o_imem_req_addr, 64'h104);

    // Redirect in the same cycle as the response: no flush state, immediate request.
    nxt();
    chk("co_rsp_seen", i_imem_rsp_valid, 1);
    i_redirect    = 1'b1;
    i_redirect_pc = 64'h200;
    #1;
    chk("co_pc_en", o_pc_en, 1);
    chk("co_pc_next", o_pc_next, 64'h200);
    nxt();
    chk("co_req_valid", o_imem_req_valid, 1);
    chk("co_req_addr", o_imem_req_addr, 64'h200);
    chk("co_fifo_empty", o_instr_valid, 0);
    nxt();
    chk("co_pc_next2", o_pc_next, 64'h204);
    nxt();
    chk("co_instr_valid", o_instr_valid, 1);
    chk("co_instr", o_instr, 32'h0020_0013);
    chk("co_instr_pc", o_instr_pc, 64'h200);

    // Errored response at 0x40, then a fetch at the top of the address space.
    do_reset();
    mem_lat       = 1;
    err_addr      = 64'h40;
    i_redirect    = 1'b1;
    i_redirect_pc = 64'h40;
    #1;
    chk("er_idle_pc_en", o_pc_en, 1);
    chk("er_idle_pc_next", o_pc_next, 64'h40);
    nxt();
    chk("er_req_addr", o_imem_req_addr, 64'h40);
    nxt();
    chk("er_pc_en", o_pc_en, 1);
    chk("er_pc_next", o_pc_next, 64'h44);
    nxt();
    chk("er_instr_valid", o_instr_valid, 1);
    chk("er_instr_err", o_instr_err, 1);
    chk("er_instr_pc", o_instr_pc, 64'h40);
    chk("er_instr", o_instr, 32'h0004_0013);
    chk("er_req_addr2", o_imem_req_addr, 64'h44);
    i_redirect    = 1'b1;
    i_redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    #1;
    chk("wr_redir_req_valid", o_imem_req_valid, 0);
    chk("wr_redir_pc_next", o_pc_next, 64'hFFFF_FFFF_FFFF_FFFC);
    nxt();
    chk("wr_req_addr", o_imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wr_fifo_empty", o_instr_valid, 0);
`ifdef FETCH_PERF_CNT_EN
    fetch_snap = o_fetch_cnt;
`endif
    nxt();
    chk("wr_pc_en", o_pc_en, 1);
    chk("wr_pc_next", o_pc_next, 64'h0);
    nxt();
    chk("wr_instr_valid", o_instr_valid, 1);
    chk("wr_instr", o_instr, 32'hFFFF_C013);
    chk("wr_instr_pc", o_instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wr_instr_err", o_instr_err, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("wr_fetch_cnt_inc", o_fetch_cnt, fetch_snap + 32'd1);
`endif

    // Reset with a request in flight returns every output to zero.
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
